// File: rtl/led_blink_driver_if.sv
// Avalon-MM slave bus bundle for the LED blink driver register file.
// Zero-wait-state shape matching the 1-bit PIO: address/chipselect/write_n.
interface led_blink_driver_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/led_blink_driver.sv
// LED pattern stage behind the LED PIO: steady or blinking drive of the LED pin,
// with a prescaled half-period programmed over an Avalon-MM slave.
module led_blink_driver #(
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    led_blink_driver_if.slave    bus,
    input  logic                 led_req,
    output logic                 led_out
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSteady   = 2'd1,
        StBlinkOn  = 2'd2,
        StBlinkOff = 2'd3
    } state_e;

    logic [1:0]            ctrl_q;
    logic [CNT_W-1:0]      period_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] pre_q;
    logic [CNT_W-1:0]      hc_q;
    logic [15:0]           tog_q;
    logic                  req_q;
    logic                  led_q;
    state_e                state_q, state_d;

    logic             wr_en;
    logic             blink;
    logic             tick;
    logic             swap;
    logic             swap_taken;
    logic             enter_on;
    logic [CNT_W-1:0] period_eff;

    assign wr_en   = bus.chipselect & ~bus.write_n;
    assign led_out = led_q;

    always_comb begin
        blink      = (state_q == StBlinkOn) || (state_q == StBlinkOff);
        tick       = blink && (pre_q == prescale_q);
        period_eff = (period_q == '0) ? CNT_W'(1) : period_q;
        // >= so a PERIOD shrunk below the running count still swaps on the next tick
        swap       = tick && (hc_q >= period_eff - CNT_W'(1));

        state_d = state_q;
        if (!req_q) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:     state_d = ctrl_q[0] ? StBlinkOn : StSteady;
                StSteady:   state_d = ctrl_q[0] ? StBlinkOn : StSteady;
                StBlinkOn:  state_d = !ctrl_q[0] ? StSteady : (swap ? StBlinkOff : StBlinkOn);
                StBlinkOff: state_d = !ctrl_q[0] ? StSteady : (swap ? StBlinkOn : StBlinkOff);
                default:    state_d = StIdle;
            endcase
        end

        swap_taken = ((state_q == StBlinkOn) && (state_d == StBlinkOff)) ||
                     ((state_q == StBlinkOff) && (state_d == StBlinkOn));
        enter_on   = (state_d == StBlinkOn) && !blink;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            period_q   <= '0;
            prescale_q <= '0;
            pre_q      <= '0;
            hc_q       <= '0;
            tog_q      <= '0;
            req_q      <= 1'b0;
            led_q      <= 1'b0;
            state_q    <= StIdle;
        end else begin
            req_q   <= led_req;
            state_q <= state_d;
            // Uses the current INV so a CTRL write shows on the pin one edge later
            led_q   <= ((state_d == StSteady) || (state_d == StBlinkOn)) ^ ctrl_q[1];

            if (wr_en) begin
                unique case (bus.address)
                    2'd0:    ctrl_q     <= bus.writedata[1:0];
                    2'd1:    period_q   <= bus.writedata[CNT_W-1:0];
                    2'd2:    prescale_q <= bus.writedata[PRESCALE_W-1:0];
                    default: ;
                endcase
            end

            if (!((state_d == StBlinkOn) || (state_d == StBlinkOff)) || enter_on) begin
                pre_q <= '0;
                hc_q  <= '0;
            end else if (tick) begin
                pre_q <= '0;
                hc_q  <= swap ? '0 : hc_q + CNT_W'(1);
            end else begin
                pre_q <= pre_q + PRESCALE_W'(1);
            end

            // A STATUS write in the same cycle as a swap leaves the count at zero
            if (wr_en && (bus.address == 2'd3)) begin
                tog_q <= '0;
            end else if (swap_taken) begin
                tog_q <= tog_q + 16'd1;
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        unique case (bus.address)
            2'd0:    bus.readdata = {30'd0, ctrl_q};
            2'd1:    bus.readdata = 32'(period_q);
            2'd2:    bus.readdata = 32'(prescale_q);
            default: bus.readdata = {tog_q, 12'd0, state_q, 1'b0, led_q};
        endcase
    end

endmodule

// File: tb/tb_led_blink_driver.sv
// Directed bench for led_blink_driver: steady, blink timing, degenerate period,
// period shrink, clear-vs-increment race, invert and asynchronous reset.
module tb_led_blink_driver;

    logic clk;
    logic reset_n;
    logic led_req;
    logic led_out;
    int   n_vec;
    int   n_err;

    led_blink_driver_if bus ();

    led_blink_driver #(
        .PRESCALE_W (16),
        .CNT_W      (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .led_req (led_req),
        .led_out (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic chk_led(input string tag, input logic exp);
        chk(tag, {31'd0, led_out}, {31'd0, exp});
    endtask

    logic [31:0] rdv;

    initial begin
        n_vec          = 0;
        n_err          = 0;
        reset_n        = 1'b0;
        led_req        = 1'b0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        step();
        step();

        // Reset state
        chk_led("rst_led", 1'b0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), rdv);
            chk($sformatf("rst_reg%0d", a), rdv, 32'd0);
        end
        reset_n = 1'b1;
        step();

        // Steady: 2-edge latency on request and release
        led_req = 1'b1;
        step();
        chk_led("steady_k", 1'b0);
        step();
        chk_led("steady_k1", 1'b1);
        rd(2'd3, rdv);
        chk("steady_status", rdv, 32'h0000_0005);
        led_req = 1'b0;
        step();
        chk_led("release_m", 1'b1);
        step();
        chk_led("release_m1", 1'b0);
        rd(2'd3, rdv);
        chk("steady_tog", rdv, 32'h0000_0000);

        // Blink: (3+1)*2 = 8 clocks per half period
        wr(2'd2, 32'd3);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'd1);
        rd(2'd2, rdv);
        chk("prescale_rd", rdv, 32'd3);
        led_req = 1'b1;
        step();
        for (int i = 0; i < 33; i++) begin
            logic e;
            step();
            e = ((i / 8) % 2) == 0;
            chk_led($sformatf("blink_%0d", i), e);
        end
        rd(2'd3, rdv);
        chk("blink_status", rdv, 32'h0004_0009);

        // Asynchronous reset mid-blink
        #2;
        reset_n = 1'b0;
        #1;
        chk_led("midrst_led", 1'b0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), rdv);
            chk($sformatf("midrst_reg%0d", a), rdv, 32'd0);
        end
        led_req = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        // Degenerate period: toggle every clock, count wraps
        wr(2'd0, 32'd1);
        led_req = 1'b1;
        step();
        step();
        chk_led("degen_0", 1'b1);
        step();
        chk_led("degen_1", 1'b0);
        step();
        chk_led("degen_2", 1'b1);
        step();
        chk_led("degen_3", 1'b0);
        rd(2'd3, rdv);
        chk("degen_cnt3", rdv, 32'h0003_000C);
        repeat (65532) step();
        rd(2'd3, rdv);
        chk("degen_ffff", rdv, 32'hFFFF_000C);
        step();
        rd(2'd3, rdv);
        chk("degen_wrap", rdv, 32'h0000_0009);
        led_req = 1'b0;
        step();
        step();
        chk_led("degen_idle", 1'b0);

        // Period shrink: PERIOD 10 -> 3 while in BLINK_ON
        wr(2'd1, 32'd10);
        led_req = 1'b1;
        step();
        for (int j = 1; j <= 6; j++) begin
            step();
            chk_led($sformatf("shrink_on%0d", j), 1'b1);
        end
        bus.address    = 2'd1;
        bus.writedata  = 32'd3;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        chk_led("shrink_on7", 1'b1);
        for (int j = 0; j < 3; j++) begin
            step();
            chk_led($sformatf("shrink_off%0d", j), 1'b0);
        end
        step();
        chk_led("shrink_back_on", 1'b1);
        rd(2'd3, rdv);
        chk("shrink_status", rdv, 32'h0003_0009);

        // Clear write in the swap cycle wins over the increment
        step();
        step();
        bus.address    = 2'd3;
        bus.writedata  = 32'hFFFF_FFFF;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        rd(2'd3, rdv);
        chk("race_clear", rdv, 32'h0000_000C);
        rd(2'd1, rdv);
        chk("race_period_kept", rdv, 32'd3);
        step();
        step();
        step();
        rd(2'd3, rdv);
        chk("race_after", rdv, 32'h0001_0009);

        // Invert while idle
        led_req = 1'b0;
        step();
        step();
        chk_led("inv_idle", 1'b0);
        rd(2'd3, rdv);
        chk("inv_idle_status", rdv, 32'h0001_0000);
        wr(2'd0, 32'd2);
        chk_led("inv_k", 1'b0);
        step();
        chk_led("inv_k1", 1'b1);
        rd(2'd0, rdv);
        chk("inv_ctrl", rdv, 32'd2);
        rd(2'd3, rdv);
        chk("inv_status", rdv, 32'h0001_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_blink_driver.md
# led_blink_driver

Avalon-MM-configurable LED pattern stage sitting directly downstream of the 1-bit LED PIO: consumes the PIO's `out_port` as a request level and drives the physical LED pin. When requested, the LED is held steady or blinked with a software-programmed period derived from a prescaled system clock. Registers are exposed on a zero-wait-state Avalon-MM slave with the same address/chipselect/write_n shape as the PIO.

## Interface
- `PRESCALE_W`, 16, width of the PRESCALE register and tick divider counter
- `CNT_W`, 16, width of the PERIOD register and half-period counter

- `clk`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `address`  in  2  register select
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe
- `writedata`  in  32  write data; fields truncated to register width
- `readdata`  out  32  combinational read mux, unused bits 0
- `led_req`  in  1  LED request level, connected to the PIO `out_port`
- `led_out`  out  1  registered LED drive

## Operation
- Register map (write when `chipselect && !write_n`):
  - 0 CTRL: bit0 MODE (0 steady, 1 blink), bit1 INV (invert output); reset 0
  - 1 PERIOD: [CNT_W-1:0] half-period in ticks; effective value P = max(PERIOD,1); reset 0
  - 2 PRESCALE: [PRESCALE_W-1:0]; one tick every PRESCALE+1 clocks; reset 0
  - 3 STATUS (read): bit0 `led_out`, bits[3:2] state encoding, bits[31:16] toggle count; any write clears toggle count only
- `readdata` = selected register, zero-extended; independent of chipselect
- `led_req` registered once into `req_q`; FSM acts on `req_q`
- FSM states (encoding): IDLE=0, STEADY=1, BLINK_ON=2, BLINK_OFF=3
  - any state, `req_q`=0 -> IDLE
  - IDLE, `req_q`=1 -> STEADY if MODE=0, BLINK_ON if MODE=1
  - STEADY -> BLINK_ON if MODE becomes 1
  - BLINK_ON/BLINK_OFF -> STEADY if MODE becomes 0
  - BLINK_ON <-> BLINK_OFF on `tick && hc >= P-1`; `hc` cleared on each swap
- Phase = 1 in STEADY and BLINK_ON, else 0; `led_out` = phase XOR INV
- Prescaler counts 0..PRESCALE, `tick` one cycle when count == PRESCALE, then wraps to 0; prescaler and `hc` held at 0 outside blink states and cleared on entering BLINK_ON
- `hc` increments on tick; `>=` compare guarantees a swap on the next tick if PERIOD is reduced below current `hc`
- Toggle count: +1 on each BLINK_ON<->BLINK_OFF swap, 16-bit wrap; clear write and increment in same cycle -> clear wins

## Timing
- Reset (async, immediate): all registers, FSM=IDLE, `req_q`=0, counters 0, `led_out`=0, `readdata` at address 0 = 0
- `led_req` sampled at edge k -> FSM and `led_out` updated at edge k+1 (2-edge latency); same for release
- Register write at edge k takes effect in FSM/counters from cycle after edge k; INV change reflected on `led_out` at edge k+1
- Blink half-period = (PRESCALE+1) * P clocks exactly; first ON phase measured from entry to BLINK_ON
- PRESCALE=0, PERIOD∈{0,1}: `led_out` toggles every clock
- Reads are combinational, zero wait states; STATUS reflects register values of current cycle

## Test plan
- Reset mid-blink: assert `reset_n`=0 during BLINK_ON -> `led_out`=0 immediately, all four registers read 0, STATUS state=0.
- Steady: CTRL=0, raise `led_req` at edge k -> `led_out`=1 after edge k+1; drop at edge m -> 0 after edge m+1; toggle count stays 0.
- Blink: PRESCALE=3, PERIOD=2, CTRL=1, `led_req`=1 -> `led_out` 8 clocks high / 8 low repeating; after 4 swaps STATUS[31:16]=4.
- Degenerate period: PRESCALE=0, PERIOD=0, MODE=1 -> `led_out` toggles every clock; count increments every clock and wraps 0xFFFF->0.
- Period shrink: PRESCALE=0, PERIOD=10, after 6 ON clocks write PERIOD=3 -> swap to BLINK_OFF on the next tick; OFF phase lasts 3 clocks.
- Clear race and invert: write address 3 in the swap cycle -> count reads 0; CTRL=2 with `led_req`=0 -> `led_out`=1 after next edge.
